// File: rtl/regfile_writeback_pkg.sv
// Shared widths, index/data types and the scoreboard ceiling for the
// register file writeback block.
package regfile_writeback_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 2 ** ADDR_W;
  localparam int CNT_W  = 2;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  pend_cnt_t;

  // Highest number of writes that may be outstanding on one register.
  localparam pend_cnt_t PEND_MAX = CNT_W'((2 ** CNT_W) - 1);

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: storage lookup, write-through forwarding of
// the current writeback, and the busy flag derived from the scoreboard.
// Optional build macro: REGFILE_ZERO_REG_EN (register 0 reads as zero).
module regfile_read_port
  import regfile_writeback_pkg::*;
(
  input  logic [ADDR_W-1:0] index,
  input  reg_data_t         regs [NREGS],
  input  pend_cnt_t         pending [NREGS],
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_index,
  input  logic [DATA_W-1:0] wb_value,
  output logic [DATA_W-1:0] value,
  output logic              busy
);

  logic      wb_hit;
  pend_cnt_t pend;

  assign wb_hit = wb_valid && (wb_index == index);
  assign pend   = pending[index];

  // Forward the in-flight writeback; a hit on the last outstanding write
  // delivers the final value now, so the operand is no longer busy.
  always_comb begin
    value = regs[index];
    busy  = (pend != '0) && !((pend == pend_cnt_t'(1)) && wb_hit);
    if (wb_hit) value = wb_value;
`ifdef REGFILE_ZERO_REG_EN
    if (index == '0) begin
      value = '0;
      busy  = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/regfile_writeback.sv
// Architectural register file (16 x 16) with writeback port, two forwarding
// read ports and a per-register pending-write scoreboard for issue stalls.
// Optional build macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
module regfile_writeback
  import regfile_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_index,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_stall,
  input  logic [ADDR_W-1:0] rd_a_index,
  output logic [DATA_W-1:0] rd_a_value,
  output logic              rd_a_busy,
  input  logic [ADDR_W-1:0] rd_b_index,
  output logic [DATA_W-1:0] rd_b_value,
  output logic              rd_b_busy,
  output logic              wb_error
);

  reg_data_t regs        [NREGS];
  pend_cnt_t pending     [NREGS];
  pend_cnt_t pending_nxt [NREGS];

  logic issue_acc;
  logic wb_dec;
  logic wb_orphan;
  logic wb_write;
  logic zero_issue;
  logic zero_wb;

`ifdef REGFILE_ZERO_REG_EN
  assign zero_issue = (issue_dest == '0);
  assign zero_wb    = (wb_index == '0);
`else
  assign zero_issue = 1'b0;
  assign zero_wb    = 1'b0;
`endif

  // A writeback retiring a reservation frees a slot in the same cycle.
  assign wb_dec      = wb_valid && (pending[wb_index] != '0);
  assign wb_orphan   = wb_valid && (pending[wb_index] == '0) && !zero_wb;
  assign wb_write    = wb_valid && !zero_wb;
  assign issue_stall = issue_valid && !zero_issue
                       && (pending[issue_dest] == PEND_MAX)
                       && !(wb_dec && (wb_index == issue_dest));
  assign issue_acc   = issue_valid && !issue_stall && !zero_issue;

  // Per-register increment/decrement; coincident events on one index cancel.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      pending_nxt[i] = pending[i];
      if (issue_acc && (issue_dest == reg_idx_t'(i))
          && !(wb_dec && (wb_index == reg_idx_t'(i))))
        pending_nxt[i] = pending[i] + pend_cnt_t'(1);
      else if (wb_dec && (wb_index == reg_idx_t'(i))
               && !(issue_acc && (issue_dest == reg_idx_t'(i))))
        pending_nxt[i] = pending[i] - pend_cnt_t'(1);
    end
  end

  // Register storage, scoreboard and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i]    <= '0;
        pending[i] <= '0;
      end
      wb_error <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) pending[i] <= pending_nxt[i];
      if (wb_write) regs[wb_index] <= wb_value;
      if (wb_orphan) wb_error <= 1'b1;
    end
  end

  regfile_read_port u_port_a (
    .index    (rd_a_index),
    .regs     (regs),
    .pending  (pending),
    .wb_valid (wb_valid),
    .wb_index (wb_index),
    .wb_value (wb_value),
    .value    (rd_a_value),
    .busy     (rd_a_busy)
  );

  regfile_read_port u_port_b (
    .index    (rd_b_index),
    .regs     (regs),
    .pending  (pending),
    .wb_valid (wb_valid),
    .wb_index (wb_index),
    .wb_value (wb_value),
    .value    (rd_b_value),
    .busy     (rd_b_busy)
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reservation, forwarding, stall,
// orphan writeback error, coincident scoreboard events, and reset.
module tb_regfile_writeback;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [3:0]  wb_index;
  logic [15:0] wb_value;
  logic        issue_valid;
  logic [3:0]  issue_dest;
  logic        issue_stall;
  logic [3:0]  rd_a_index;
  logic [15:0] rd_a_value;
  logic        rd_a_busy;
  logic [3:0]  rd_b_index;
  logic [15:0] rd_b_value;
  logic        rd_b_busy;
  logic        wb_error;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_index    (wb_index),
    .wb_value    (wb_value),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_stall (issue_stall),
    .rd_a_index  (rd_a_index),
    .rd_a_value  (rd_a_value),
    .rd_a_busy   (rd_a_busy),
    .rd_b_index  (rd_b_index),
    .rd_b_value  (rd_b_value),
    .rd_b_busy   (rd_b_busy),
    .wb_error    (wb_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid    = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    wb_valid = 1'b0; wb_index = '0; wb_value = '0;
    issue_valid = 1'b0; issue_dest = '0;
    rd_a_index = 4'd2; rd_b_index = 4'd11;

    // Reset state
    #12;
    check("rst_a_val",  32'(rd_a_value), 32'h0);
    check("rst_b_val",  32'(rd_b_value), 32'h0);
    check("rst_a_busy", 32'(rd_a_busy),  32'd0);
    check("rst_b_busy", 32'(rd_b_busy),  32'd0);
    check("rst_stall",  32'(issue_stall), 32'd0);
    check("rst_err",    32'(wb_error),   32'd0);
    #5 rst = 1'b1;
    tick();

    // Reserve 5, writeback two cycles later
    issue_valid = 1'b1; issue_dest = 4'd5; #1;
    check("r5_stall", 32'(issue_stall), 32'd0);
    tick();
    idle(); rd_a_index = 4'd5; #1;
    check("r5_busy_mid", 32'(rd_a_busy), 32'd1);
    check("r5_val_mid",  32'(rd_a_value), 32'h0);
    tick();
    wb_valid = 1'b1; wb_index = 4'd5; wb_value = 16'hBEEF; #1;
    check("r5_fwd_val",  32'(rd_a_value), 32'hBEEF);
    check("r5_fwd_busy", 32'(rd_a_busy), 32'd0);
    tick();
    idle(); #1;
    check("r5_store_val",  32'(rd_a_value), 32'hBEEF);
    check("r5_store_busy", 32'(rd_a_busy), 32'd0);

    // Fill register 3 to the limit
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1'b1; issue_dest = 4'd3; #1;
      check("r3_fill_stall", 32'(issue_stall), 32'd0);
      tick();
    end
    issue_valid = 1'b1; issue_dest = 4'd3; rd_b_index = 4'd3; #1;
    check("r3_full_stall", 32'(issue_stall), 32'd1);
    check("r3_full_busy",  32'(rd_b_busy), 32'd1);
    tick();
    wb_valid = 1'b1; wb_index = 4'd3; wb_value = 16'h0333; #1;
    check("r3_freed_stall", 32'(issue_stall), 32'd0);
    check("r3_freed_busy",  32'(rd_b_busy), 32'd1);
    tick();
    wb_valid = 1'b0; #1;
    check("r3_still_full", 32'(issue_stall), 32'd1);
    tick();
    // Drain three writes; the last one clears busy in its own cycle
    issue_valid = 1'b0; wb_valid = 1'b1; wb_index = 4'd3;
    wb_value = 16'h3001; #1;
    check("r3_drain1_busy", 32'(rd_b_busy), 32'd1);
    tick();
    wb_value = 16'h3002; #1;
    check("r3_drain2_busy", 32'(rd_b_busy), 32'd1);
    tick();
    wb_value = 16'h3003; #1;
    check("r3_drain3_busy", 32'(rd_b_busy), 32'd0);
    check("r3_drain3_val",  32'(rd_b_value), 32'h3003);
    tick();
    idle(); #1;
    check("r3_empty_busy", 32'(rd_b_busy), 32'd0);
    check("r3_empty_val",  32'(rd_b_value), 32'h3003);
    check("r3_no_err",     32'(wb_error), 32'd0);

    // Register 0
    rd_a_index = 4'd0;
`ifdef REGFILE_ZERO_REG_EN
    for (int k = 0; k < 4; k++) begin
      issue_valid = 1'b1; issue_dest = 4'd0; #1;
      check("z0_issue_stall", 32'(issue_stall), 32'd0);
      tick();
    end
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_index = 4'd0; wb_value = 16'hFFFF; #1;
    check("z0_fwd_val",  32'(rd_a_value), 32'h0);
    check("z0_fwd_busy", 32'(rd_a_busy), 32'd0);
    tick();
    idle(); #1;
    check("z0_val",  32'(rd_a_value), 32'h0);
    check("z0_busy", 32'(rd_a_busy), 32'd0);
    check("z0_err",  32'(wb_error), 32'd0);
`else
    issue_valid = 1'b1; issue_dest = 4'd0; #1;
    check("r0_issue_stall", 32'(issue_stall), 32'd0);
    tick();
    issue_valid = 1'b0; #1;
    check("r0_busy_mid", 32'(rd_a_busy), 32'd1);
    wb_valid = 1'b1; wb_index = 4'd0; wb_value = 16'hFFFF; #1;
    check("r0_fwd_val",  32'(rd_a_value), 32'hFFFF);
    check("r0_fwd_busy", 32'(rd_a_busy), 32'd0);
    tick();
    idle(); #1;
    check("r0_val", 32'(rd_a_value), 32'hFFFF);
    check("r0_err", 32'(wb_error), 32'd0);
`endif

    // Orphan writeback to 7
    rd_a_index = 4'd7;
    wb_valid = 1'b1; wb_index = 4'd7; wb_value = 16'h1234; #1;
    check("r7_fwd_val", 32'(rd_a_value), 32'h1234);
    check("r7_err_pre", 32'(wb_error), 32'd0);
    tick();
    idle(); #1;
    check("r7_err",  32'(wb_error), 32'd1);
    check("r7_val",  32'(rd_a_value), 32'h1234);
    check("r7_busy", 32'(rd_a_busy), 32'd0);
    // Counter must still be 0 (an underflow to 3 would stall here)
    issue_valid = 1'b1; issue_dest = 4'd7; #1;
    check("r7_no_underflow", 32'(issue_stall), 32'd0);
    tick();
    issue_valid = 1'b0; #1;
    check("r7_busy_one", 32'(rd_a_busy), 32'd1);

    // Same-cycle issue and writeback on 9 with one outstanding
    issue_valid = 1'b1; issue_dest = 4'd9; rd_b_index = 4'd9; #1;
    tick();
    wb_valid = 1'b1; wb_index = 4'd9; wb_value = 16'h0909; #1;
    check("r9_same_stall", 32'(issue_stall), 32'd0);
    check("r9_same_busy",  32'(rd_b_busy), 32'd0);
    tick();
    idle(); #1;
    check("r9_after_busy", 32'(rd_b_busy), 32'd1);
    check("r9_after_val",  32'(rd_b_value), 32'h0909);
    check("err_sticky",    32'(wb_error), 32'd1);

    // Different indices in one cycle: retire 7, reserve 10
    issue_valid = 1'b1; issue_dest = 4'd10;
    wb_valid = 1'b1; wb_index = 4'd7; wb_value = 16'h7777; #1;
    tick();
    idle(); rd_b_index = 4'd10; #1;
    check("r7_retired_busy", 32'(rd_a_busy), 32'd0);
    check("r7_retired_val",  32'(rd_a_value), 32'h7777);
    check("r10_busy",        32'(rd_b_busy), 32'd1);

    // Both ports on one index
    rd_a_index = 4'd9; rd_b_index = 4'd9; #1;
    check("dual_a_val", 32'(rd_a_value), 32'h0909);
    check("dual_b_val", 32'(rd_b_value), 32'h0909);

    // Asynchronous reset mid-operation
    rst = 1'b0; #1;
    check("mrst_val",   32'(rd_a_value), 32'h0);
    check("mrst_busy",  32'(rd_b_busy), 32'd0);
    check("mrst_err",   32'(wb_error), 32'd0);
    rst = 1'b1;
    tick();
    rd_b_index = 4'd10; #1;
    check("mrst_r10_busy", 32'(rd_b_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side counterpart to the read-stage forwarding mux of the 16-bit core.
- Holds the architectural register file (16 x 16-bit) and owns the writeback port that produces the update index/value pair consumed by operand forwarding.
- Keeps a per-register pending-write scoreboard so issue can stall on resource limits, and so readers know whether a fetched operand is still in flight.
- Sits between the writeback stage (writer) and decode/issue (readers).

Parameters:
- DATA_W, 16, register and data width
- ADDR_W, 4, register index width
- NREGS, 16, number of registers (2**ADDR_W)
- CNT_W, 2, width of per-register pending counter; max in-flight writes per register = 2**CNT_W-1 = 3

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- wb_valid  input  1  writeback strobe, one write per cycle
- wb_index  input  ADDR_W  writeback destination register
- wb_value  input  DATA_W  writeback data
- issue_valid  input  1  issue stage requests to reserve a destination
- issue_dest  input  ADDR_W  destination being reserved
- issue_stall  output  1  reservation refused this cycle (combinational)
- rd_a_index  input  ADDR_W  read port A index
- rd_a_value  output  DATA_W  read port A data (combinational)
- rd_a_busy  output  1  port A operand still has outstanding writes
- rd_b_index  input  ADDR_W  read port B index
- rd_b_value  output  DATA_W  read port B data
- rd_b_busy  output  1  port B operand still has outstanding writes
- wb_error  output  1  sticky: writeback arrived with no reservation

Behaviour:
- Reset (rst low, asynchronous):
  - All registers = 0; all pending counters = 0; wb_error = 0.
  - Combinational outputs follow from the cleared state: busy = 0, stall = 0.
  - Reset mid-operation discards all reservations.
- Write:
  - On posedge clk with wb_valid=1: regs[wb_index] <= wb_value.
  - Write is performed even when wb_error is raised.
- Read:
  - Combinational, zero latency.
  - If wb_valid and wb_index==rd_x_index, then rd_x_value = wb_value (write-through forwarding); otherwise rd_x_value = regs[rd_x_index].
  - Both ports are independent; the same index on both ports is legal.
- Scoreboard, with acc = issue_valid && !issue_stall:
  - Case acc only: pending[issue_dest] += 1.
  - Case wb_valid with pending[wb_index] != 0: pending[wb_index] -= 1.
  - Both events on the same index in the same cycle: net count unchanged.
  - Both events on different indices: both updates apply.
- issue_stall:
  - Asserted when issue_valid && pending[issue_dest] == max, unless a valid decrement to the same index occurs this cycle.
  - Never asserted when issue_valid=0.
- rd_x_busy:
  - Asserted when pending[idx] != 0.
  - Exception: the count is 1 and a valid writeback to idx occurs this cycle. That write is the last outstanding one and is forwarded, so busy = 0.
- wb_error:
  - Set on posedge clk when wb_valid && pending[wb_index] == 0.
  - The counter stays at 0 (no underflow).
  - Cleared only by reset.
- All index comparisons are full ADDR_W equality; no wrap or aliasing.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN
- Defined:
  - Register 0 is hardwired to zero; reads of index 0 return 0 and are never forwarded.
  - Writes to index 0 are dropped.
  - pending[0] is never incremented; reads of index 0 never assert busy.
  - issue to dest 0 never stalls.
  - A writeback to 0 does not set wb_error.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package:
  - DATA_W, ADDR_W, NREGS, CNT_W
  - Typedefs reg_idx_t (ADDR_W bits) and reg_data_t (DATA_W bits)
  - Constant PEND_MAX = 2**CNT_W-1
- Sub-module regfile_read_port, instantiated twice:
  - Inputs: index, regs array slice, writeback triple, pending count.
  - Outputs: value and busy, including the forwarding and last-write busy-clear logic.

Test Plan:
- Reset, then read any index on A/B -> value 0x0000, busy 0, issue_stall 0, wb_error 0.
- Issue dest 5, then wb 5=0xBEEF two cycles later -> rd_a(5) busy=1 in the between cycle. In the wb cycle, value=0xBEEF (forwarded) and busy=0; afterwards value=0xBEEF from storage.
- Three issues to dest 3 with no wb, then a fourth issue to 3 -> issue_stall=1. Repeat the fourth issue together with wb to 3 -> stall=0 and count stays 3.
- wb_valid to index 7 with no reservation, value 0x1234 -> wb_error=1 next cycle, regs[7]=0x1234, pending[7] stays 0. wb_error stays high until rst.
- Issue 9 and wb 9 in the same cycle, with pending[9]=1 beforehand -> pending remains 1 and rd_b(9) busy=1 the next cycle.
- With REGFILE_ZERO_REG_EN defined, wb 0=0xFFFF -> rd_a(0)=0x0000 (also in the same cycle), busy=0, wb_error=0. Issue to dest 0 ×4 -> issue_stall never asserted.
